// File: rtl/cmp_arb_pkg.sv
// Shared constants for signed_cmp_arbiter: FSM state codes,
// flag bit positions and statistics counter width.
package cmp_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int F_EQ = 0;
    localparam int F_GT = 1;
    localparam int F_LT = 2;

    localparam int STAT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first asserted req at or after ptr.
// Ports: req (requests), ptr (start index) -> gnt (one-hot), gnt_id.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic w_found;

    always_comb begin
        int v_idx;
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        v_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Walk from ptr upward, wrapping at NREQ (not a power of 2 in general).
            v_idx = int'(ptr) + k;
            if (v_idx >= NREQ) v_idx = v_idx - NREQ;
            if (!w_found && req[IDW'(v_idx)]) begin
                w_found             = 1'b1;
                gnt[IDW'(v_idx)]    = 1'b1;
                gnt_id              = IDW'(v_idx);
            end
        end
    end

endmodule

// File: rtl/signed_cmp_arbiter.sv
// One registered signed comparator shared by NREQ requesters via round-robin.
// Ports: req_valid/req_ready/req_a/req_b in, rsp_valid/rsp_ready/rsp_id/flags out.
// Optional CMP_ARB_STAT_EN: stat_clr in, stat_eq/stat_gt/stat_lt saturating counters out.
module signed_cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_equal,
    output logic                  rsp_greater,
    output logic                  rsp_lower
`ifdef CMP_ARB_STAT_EN
    ,
    input  logic                  stat_clr,
    output logic [STAT_W-1:0]     stat_eq,
    output logic [STAT_W-1:0]     stat_gt,
    output logic [STAT_W-1:0]     stat_lt
`endif
);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_flags;

    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_acc;
    logic [WIDTH:0]   w_diff;
    logic [2:0]       w_flags;
    logic [IDW-1:0]   w_ptr_nxt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req_valid),
        .ptr    (r_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    assign w_acc = |req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_acc) w_next = ST_CMP;
            ST_CMP:  w_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // rst_n gates req_ready so no grant is offered while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && r_state == ST_IDLE) req_ready = w_gnt;
        rsp_valid = (r_state == ST_RESP);
    end

    // One extra bit keeps the subtraction free of overflow.
    assign w_diff = {r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b};

    always_comb begin
        w_flags       = '0;
        w_flags[F_EQ] = (w_diff == '0);
        w_flags[F_LT] = w_diff[WIDTH];
        w_flags[F_GT] = !w_flags[F_EQ] && !w_flags[F_LT];
    end

    assign w_ptr_nxt = (int'(r_id) == NREQ - 1) ? '0 : r_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_id    <= '0;
            r_flags <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_acc) begin
                r_a  <= req_a[int'(w_gnt_id)*WIDTH +: WIDTH];
                r_b  <= req_b[int'(w_gnt_id)*WIDTH +: WIDTH];
                r_id <= w_gnt_id;
            end
            if (r_state == ST_CMP) r_flags <= w_flags;
            if (rsp_valid && rsp_ready) r_ptr <= w_ptr_nxt;
        end
    end

    assign rsp_id      = r_id;
    assign rsp_equal   = r_flags[F_EQ];
    assign rsp_greater = r_flags[F_GT];
    assign rsp_lower   = r_flags[F_LT];

`ifdef CMP_ARB_STAT_EN
    logic w_done;
    assign w_done = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_eq <= '0;
            stat_gt <= '0;
            stat_lt <= '0;
        end else if (stat_clr) begin
            stat_eq <= '0;
            stat_gt <= '0;
            stat_lt <= '0;
        end else if (w_done) begin
            if (rsp_equal && stat_eq != '1)   stat_eq <= stat_eq + 1'b1;
            if (rsp_greater && stat_gt != '1) stat_gt <= stat_gt + 1'b1;
            if (rsp_lower && stat_lt != '1)   stat_lt <= stat_lt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_signed_cmp_arbiter.sv
// Scoreboard bench for signed_cmp_arbiter: random and directed requests,
// expected grants/results queued by a spec-level model, checked by a monitor.
module tb_signed_cmp_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic           rsp_equal;
    logic           rsp_greater;
    logic           rsp_lower;
`ifdef CMP_ARB_STAT_EN
    logic           stat_clr;
    logic [15:0]    stat_eq;
    logic [15:0]    stat_gt;
    logic [15:0]    stat_lt;
    int             m_eq = 0;
    int             m_gt = 0;
    int             m_lt = 0;
`endif

    signed_cmp_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_equal   (rsp_equal),
        .rsp_greater (rsp_greater),
        .rsp_lower   (rsp_lower)
`ifdef CMP_ARB_STAT_EN
        ,
        .stat_clr    (stat_clr),
        .stat_eq     (stat_eq),
        .stat_gt     (stat_gt),
        .stat_lt     (stat_lt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int   id;
        logic eq;
        logic gt;
        logic lt;
        int   cyc;
    } exp_t;

    exp_t         exp_q[$];
    int           id_log[$];
    int           n_cmp  = 0;
    int           n_err  = 0;
    int           cyc    = 0;
    int           n_done = 0;
    int           m_ptr  = 0;
    bit           busy   = 0;
    bit           cont   = 0;
    logic [N-1:0] acc_vec = '0;
    logic [W-1:0] bnd[4] = '{8'h80, 8'h7F, 8'h00, 8'hFF};

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Nearest valid requester at or after p, counting forward with wrap.
    function automatic int model_grant(logic [N-1:0] v, int p);
        int best = -1;
        int bd   = N;
        for (int i = 0; i < N; i++) begin
            if (v[i] && ((i - p + N) % N) < bd) begin
                bd   = (i - p + N) % N;
                best = i;
            end
        end
        return best;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [N-1:0] e_rdy;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           g;
        bit           was_busy;
        bit           rsp_due;
        bit           done;
        if (!rst_n) begin
            exp_q.delete();
            busy    = 0;
            m_ptr   = 0;
            acc_vec = '0;
`ifdef CMP_ARB_STAT_EN
            m_eq = 0; m_gt = 0; m_lt = 0;
`endif
        end else begin
            was_busy = busy;
            rsp_due  = was_busy && (cyc >= exp_q[0].cyc);
            done     = rsp_due && rsp_ready;
            chk("rsp_valid", rsp_valid, rsp_due);
            if (rsp_due) begin
                chk("rsp_id", rsp_id, exp_q[0].id);
                chk("rsp_flags", {rsp_equal, rsp_greater, rsp_lower},
                    {exp_q[0].eq, exp_q[0].gt, exp_q[0].lt});
            end
`ifdef CMP_ARB_STAT_EN
            chk("stat_eq", stat_eq, m_eq);
            chk("stat_gt", stat_gt, m_gt);
            chk("stat_lt", stat_lt, m_lt);
            if (stat_clr) begin
                m_eq = 0; m_gt = 0; m_lt = 0;
            end else if (done) begin
                if (exp_q[0].eq && m_eq < 65535) m_eq++;
                if (exp_q[0].gt && m_gt < 65535) m_gt++;
                if (exp_q[0].lt && m_lt < 65535) m_lt++;
            end
`endif
            g     = model_grant(req_valid, m_ptr);
            e_rdy = '0;
            if (!was_busy && g >= 0) e_rdy[g] = 1'b1;
            chk("req_ready", req_ready, e_rdy);
            acc_vec = e_rdy;
            if (!was_busy && g >= 0) begin
                a = req_a[g*W +: W];
                b = req_b[g*W +: W];
                exp_q.push_back('{g, a == b, $signed(a) > $signed(b),
                                  $signed(a) < $signed(b), cyc + 2});
                busy = 1;
            end
            if (done) begin
                m_ptr = (exp_q[0].id + 1) % N;
                id_log.push_back(exp_q[0].id);
                void'(exp_q.pop_front());
                busy = 0;
                n_done++;
            end
        end
    end

    task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
    endtask

    task automatic rnd_pair(output logic [W-1:0] a, output logic [W-1:0] b);
        case ($urandom_range(0, 5))
            0: begin a = W'($urandom); b = a; end
            1: begin a = bnd[$urandom_range(0, 3)]; b = bnd[$urandom_range(0, 3)]; end
            default: begin a = W'($urandom); b = W'($urandom); end
        endcase
    endtask

    task automatic tick();
        logic [W-1:0] a;
        logic [W-1:0] b;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_vec[i]) begin
                if (cont) begin
                    rnd_pair(a, b);
                    set_req(i, a, b);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_done(int target, int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            tick();
            k++;
        end
        if (n_done < target) chk("done_timeout", n_done, target);
    endtask

    task automatic wait_rsp(int budget);
        int k = 0;
        while (!rsp_valid && k < budget) begin
            tick();
            k++;
        end
        chk("rsp_timeout", rsp_valid, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           base;
        int           k;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
`ifdef CMP_ARB_STAT_EN
        stat_clr  = 1'b0;
`endif
        #12;
        req_valid = '1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_flags", {rsp_equal, rsp_greater, rsp_lower}, 0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;

        // Overflow-prone operand pairs and equality.
        rsp_ready = 1'b1;
        set_req(0, 8'h7F, 8'h80);
        wait_done(n_done + 1, 20);
        set_req(0, 8'h80, 8'h7F);
        wait_done(n_done + 1, 20);
        set_req(0, 8'hA5, 8'hA5);
        wait_done(n_done + 1, 20);

        // All requesters continuously valid: strict rotation from 0.
        do_reset();
        base = id_log.size();
        cont = 1;
        for (int i = 0; i < N; i++) begin
            rnd_pair(a, b);
            set_req(i, a, b);
        end
        wait_done(n_done + 5, 40);
        cont      = 0;
        req_valid = '0;
        for (int j = 0; j < 5 && base + j < id_log.size(); j++)
            chk("rr_order", id_log[base+j], j % N);

`ifdef CMP_ARB_STAT_EN
        do_reset();
        for (int j = 0; j < 3; j++) begin
            set_req(0, 8'h10, 8'hF0);
            wait_done(n_done + 1, 20);
        end
        for (int j = 0; j < 2; j++) begin
            set_req(0, 8'h5A, 8'h5A);
            wait_done(n_done + 1, 20);
        end
        chk("stat_gt_cnt", stat_gt, 3);
        chk("stat_eq_cnt", stat_eq, 2);
        chk("stat_lt_cnt", stat_lt, 0);
        rsp_ready = 1'b0;
        set_req(0, 8'h01, 8'h02);
        wait_rsp(20);
        stat_clr  = 1'b1;
        rsp_ready = 1'b1;
        tick();
        stat_clr  = 1'b0;
        chk("stat_clr_all", {stat_eq, stat_gt, stat_lt}, 0);
`endif

        // Backpressure: response held for 5 cycles with another request pending.
        rsp_ready = 1'b0;
        set_req(1, 8'h05, 8'hFB);
        set_req(2, 8'h40, 8'hC0);
        wait_rsp(20);
        repeat (5) tick();
        rsp_ready = 1'b1;
        wait_done(n_done + 2, 20);

        // Reset while a transaction sits in CMP.
        set_req(1, 8'h33, 8'h22);
        k = 0;
        while (req_valid[1] && k < 20) begin
            tick();
            k++;
        end
        chk("acc_timeout", req_valid[1], 0);
        #2;
        rst_n = 1'b0;
        set_req(2, 8'h81, 8'h01);
        set_req(3, 8'h00, 8'h00);
        #1;
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_rsp_id", rsp_id, 0);
        chk("arst_flags", {rsp_equal, rsp_greater, rsp_lower}, 0);
        chk("arst_req_ready", req_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        base = id_log.size();
        wait_done(n_done + 1, 10);
        if (id_log.size() > base) chk("post_rst_id", id_log[base], 2);
        wait_done(n_done + 1, 10);

        // Random traffic with random backpressure and early withdrawals.
        for (int c = 0; c < 400; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    rnd_pair(a, b);
                    set_req(i, a, b);
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            tick();
        end
        rsp_ready = 1'b1;
        k = 0;
        while ((req_valid != '0 || busy) && k < 200) begin
            tick();
            k++;
        end
        chk("drain", {31'(req_valid != '0), busy}, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
